// File: rtl/ct_rst_pkg.sv
// ct_rst_pkg -- shared definitions for the reset subsystem.
//   Holds the fence.t controller state encoding and the default
//   timing parameters, plus a helper that sizes the shared counter.
package ct_rst_pkg;

  localparam int FENCET_PULSE_CYC_DEF  = 4;
  localparam int FENCET_SETTLE_CYC_DEF = 8;
  localparam int FENCET_DRAIN_MAX_DEF  = 1023;

  typedef enum logic [2:0] {
    FT_IDLE   = 3'd0,
    FT_DRAIN  = 3'd1,
    FT_PULSE  = 3'd2,
    FT_SETTLE = 3'd3,
    FT_DONE   = 3'd4
  } fencet_state_e;

  // The one counter is reused for drain, pulse and settle timing.
  // Its width is normally set by DRAIN_MAX. Any wider pulse or settle
  // load is also covered so a small DRAIN_MAX can't truncate them.
  function automatic int fencet_cnt_w(input int drain_max,
                                      input int pulse_cyc,
                                      input int settle_cyc);
    int m;
    m = drain_max;
    if (pulse_cyc > m)  m = pulse_cyc;
    if (settle_cyc > m) m = settle_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ct_rst_fencet_ctrl_if.sv
// ct_rst_fencet_ctrl_if -- the fence.t handshake bundle between the
// retire/unit side and the fence.t controller.
//   rtu_fencet_req          : one-cycle pulse, fence.t retired
//   lsu/ifu/biu_fencet_idle : unit quiescent, level
//   pipe4_fencet            : microarchitectural reset request, level
//   fencet_busy             : sequence in progress, level
//   fencet_done             : one-cycle completion pulse
//   fencet_timeout          : one-cycle drain-timeout pulse
// Handshake: there is no backpressure. A req is accepted only while
// busy is low. Every accepted req gets exactly one done, unless the
// architectural reset aborts the sequence.
interface ct_rst_fencet_ctrl_if;
  logic rtu_fencet_req;
  logic lsu_fencet_idle;
  logic ifu_fencet_idle;
  logic biu_fencet_idle;
  logic pipe4_fencet;
  logic fencet_busy;
  logic fencet_done;
  logic fencet_timeout;

  modport master (
    output rtu_fencet_req, lsu_fencet_idle, ifu_fencet_idle, biu_fencet_idle,
    input  pipe4_fencet, fencet_busy, fencet_done, fencet_timeout
  );

  modport slave (
    input  rtu_fencet_req, lsu_fencet_idle, ifu_fencet_idle, biu_fencet_idle,
    output pipe4_fencet, fencet_busy, fencet_done, fencet_timeout
  );
endinterface

// File: rtl/ct_rst_fencet_ctrl.sv
// ct_rst_fencet_ctrl -- fence.t sequencer.
//   Once fence.t retires, this block waits for the LSU, IFU and BIU to
//   drain, or for the drain limit to expire. It then raises
//   pipe4_fencet for PULSE_CYC cycles and waits SETTLE_CYC cycles so
//   the unit resets are released. Finally it pulses fencet_done.
// Ports:
//   forever_coreclk  : free-running clock
//   cpurst_b         : async active-low architectural reset
//   rtu_fencet_req   : fence.t retired (pulse, ignored unless idle)
//   *_fencet_idle    : per-unit quiescent flags (sampled in DRAIN only)
//   pipe4_fencet     : registered reset request to the reset top
//   fencet_busy      : high from the cycle after req through DONE
//   fencet_done      : one-cycle completion pulse
//   fencet_timeout   : one-cycle pulse when the drain wait expired
//   fencet_dbg_state : current FSM state, for observation
module ct_rst_fencet_ctrl
  import ct_rst_pkg::*;
#(
  parameter int PULSE_CYC  = FENCET_PULSE_CYC_DEF,
  parameter int SETTLE_CYC = FENCET_SETTLE_CYC_DEF,
  parameter int DRAIN_MAX  = FENCET_DRAIN_MAX_DEF
) (
  input  logic          forever_coreclk,
  input  logic          cpurst_b,
  input  logic          rtu_fencet_req,
  input  logic          lsu_fencet_idle,
  input  logic          ifu_fencet_idle,
  input  logic          biu_fencet_idle,
  output logic          pipe4_fencet,
  output logic          fencet_busy,
  output logic          fencet_done,
  output logic          fencet_timeout,
  output fencet_state_e fencet_dbg_state
);

  localparam int CNT_W = fencet_cnt_w(DRAIN_MAX, PULSE_CYC, SETTLE_CYC);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_MAX);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  fencet_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pipe4_q, pipe4_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             all_idle;

  assign all_idle = lsu_fencet_idle & ifu_fencet_idle & biu_fencet_idle;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      FT_IDLE: begin
        if (rtu_fencet_req) begin
          state_d = FT_DRAIN;
          cnt_d   = '0;
        end
      end
      FT_DRAIN: begin
        // Idle wins over the limit: if the drain completes in the same
        // cycle the limit is reached, the wait did not time out.
        if (all_idle) begin
          state_d = FT_PULSE;
          cnt_d   = PULSE_LOAD;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d   = FT_PULSE;
          cnt_d     = PULSE_LOAD;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FT_PULSE: begin
        if (cnt_q == '0) begin
          state_d = FT_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FT_SETTLE: begin
        if (cnt_q == '0) state_d = FT_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FT_DONE: state_d = FT_IDLE;
      default: begin
        state_d = FT_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The outputs are decoded from the next state and registered. This
    // makes them glitch-free and aligned with the state they describe.
    pipe4_d = (state_d == FT_PULSE);
    busy_d  = (state_d != FT_IDLE);
    done_d  = (state_d == FT_DONE);
  end

  always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= FT_IDLE;
      cnt_q     <= '0;
      pipe4_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pipe4_q   <= pipe4_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign pipe4_fencet     = pipe4_q;
  assign fencet_busy      = busy_q;
  assign fencet_done      = done_q;
  assign fencet_timeout   = timeout_q;
  assign fencet_dbg_state = state_q;

endmodule

// File: tb/tb_ct_rst_fencet_ctrl.sv
// tb_ct_rst_fencet_ctrl -- directed bench for the fence.t sequencer.
// Cycle 0 is the cycle in which rtu_fencet_req is high. Outputs are
// sampled 1 time unit after each rising edge. Two instances share the
// inputs: one uses the defaults, and one uses DRAIN_MAX=15 for the
// timeout case. A two-flop model of the reset top produces ifu_rst_b.
module tb_ct_rst_fencet_ctrl;
  import ct_rst_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cpurst_b;
  ct_rst_fencet_ctrl_if fif();

  logic          pipe_t, busy_t, done_t, to_t;
  fencet_state_e st_d, st_t;

  ct_rst_fencet_ctrl dut (
    .forever_coreclk (clk),
    .cpurst_b        (cpurst_b),
    .rtu_fencet_req  (fif.rtu_fencet_req),
    .lsu_fencet_idle (fif.lsu_fencet_idle),
    .ifu_fencet_idle (fif.ifu_fencet_idle),
    .biu_fencet_idle (fif.biu_fencet_idle),
    .pipe4_fencet    (fif.pipe4_fencet),
    .fencet_busy     (fif.fencet_busy),
    .fencet_done     (fif.fencet_done),
    .fencet_timeout  (fif.fencet_timeout),
    .fencet_dbg_state(st_d)
  );

  ct_rst_fencet_ctrl #(.DRAIN_MAX(15)) dut_t (
    .forever_coreclk (clk),
    .cpurst_b        (cpurst_b),
    .rtu_fencet_req  (fif.rtu_fencet_req),
    .lsu_fencet_idle (fif.lsu_fencet_idle),
    .ifu_fencet_idle (fif.ifu_fencet_idle),
    .biu_fencet_idle (fif.biu_fencet_idle),
    .pipe4_fencet    (pipe_t),
    .fencet_busy     (busy_t),
    .fencet_done     (done_t),
    .fencet_timeout  (to_t),
    .fencet_dbg_state(st_t)
  );

  // Reset-top model: a one-cycle fence latch, then the per-unit reset flop.
  logic fence_latch_q, ifu_rst_b_q;
  always_ff @(posedge clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      fence_latch_q <= 1'b0;
      ifu_rst_b_q   <= 1'b1;
    end else begin
      fence_latch_q <= fif.pipe4_fencet;
      ifu_rst_b_q   <= ~fence_latch_q;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic int first_one(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last_one(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  logic [63:0] rec_pipe, rec_busy, rec_done, rec_to, rec_ifu_low;
  logic [63:0] rec_pipe_t, rec_done_t, rec_to_t;

  task automatic do_reset();
    cpurst_b            = 1'b0;
    fif.rtu_fencet_req  = 1'b0;
    fif.lsu_fencet_idle = 1'b1;
    fif.ifu_fencet_idle = 1'b1;
    fif.biu_fencet_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One sequence: req in cycle 0, optional second req, late lsu/biu idle,
  // and optional cpurst_b assertion in a given cycle.
  task automatic run_seq(input int n, input int lsu_rise, input int biu_rise,
                         input int req2_cyc, input int rst_cyc);
    rec_pipe = '0; rec_busy = '0; rec_done = '0; rec_to = '0; rec_ifu_low = '0;
    rec_pipe_t = '0; rec_done_t = '0; rec_to_t = '0;
    for (int c = 0; c < n; c++) begin
      fif.rtu_fencet_req  = (c == 0) || (c == req2_cyc);
      fif.lsu_fencet_idle = (c >= lsu_rise);
      fif.biu_fencet_idle = (c >= biu_rise);
      fif.ifu_fencet_idle = 1'b1;
      if (c == rst_cyc) begin
        cpurst_b = 1'b0;
        #1;
        check_eq("rst_async_pipe4",   int'(fif.pipe4_fencet),   0);
        check_eq("rst_async_busy",    int'(fif.fencet_busy),    0);
        check_eq("rst_async_done",    int'(fif.fencet_done),    0);
        check_eq("rst_async_timeout", int'(fif.fencet_timeout), 0);
      end
      rec_pipe[c]    = fif.pipe4_fencet;
      rec_busy[c]    = fif.fencet_busy;
      rec_done[c]    = fif.fencet_done;
      rec_to[c]      = fif.fencet_timeout;
      rec_ifu_low[c] = ~ifu_rst_b_q;
      rec_pipe_t[c]  = pipe_t;
      rec_done_t[c]  = done_t;
      rec_to_t[c]    = to_t;
      @(posedge clk);
      #1;
      if (c == rst_cyc) cpurst_b = 1'b1;
    end
    fif.rtu_fencet_req = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("reset_pipe4",   int'(fif.pipe4_fencet),   0);
    check_eq("reset_busy",    int'(fif.fencet_busy),    0);
    check_eq("reset_done",    int'(fif.fencet_done),    0);
    check_eq("reset_timeout", int'(fif.fencet_timeout), 0);
    check_eq("reset_state",   int'(st_d), int'(FT_IDLE));

    // Everything already idle: pulse in cycles 2-5, done in 14, busy in 1-14.
    run_seq(24, 0, 0, -1, -1);
    check_eq("t1_pipe_first", first_one(rec_pipe), 2);
    check_eq("t1_pipe_last",  last_one(rec_pipe), 5);
    check_eq("t1_pipe_cnt",   $countones(rec_pipe), 4);
    check_eq("t1_done_cyc",   first_one(rec_done), 14);
    check_eq("t1_done_cnt",   $countones(rec_done), 1);
    check_eq("t1_busy_first", first_one(rec_busy), 1);
    check_eq("t1_busy_last",  last_one(rec_busy), 14);
    check_eq("t1_busy_cnt",   $countones(rec_busy), 14);
    check_eq("t1_timeout",    $countones(rec_to), 0);
    // Reset top: ifu reset is low in cycles 4-7, released before done.
    check_eq("t1_ifu_first",  first_one(rec_ifu_low), 4);
    check_eq("t1_ifu_last",   last_one(rec_ifu_low), 7);
    check_eq("t1_ifu_cnt",    $countones(rec_ifu_low), 4);

    // lsu is not idle until cycle 20, so the pulse starts in cycle 21.
    do_reset();
    run_seq(40, 20, 0, -1, -1);
    check_eq("t2_pipe_first", first_one(rec_pipe), 21);
    check_eq("t2_pipe_cnt",   $countones(rec_pipe), 4);
    check_eq("t2_timeout",    $countones(rec_to), 0);
    check_eq("t2_done_cyc",   first_one(rec_done), 33);

    // biu is stuck low and DRAIN_MAX=15: the counter hits 15 in cycle 16,
    // so timeout and the pulse start in cycle 17 and done comes in 29.
    do_reset();
    run_seq(40, 0, 1000, -1, -1);
    check_eq("t3_to_first",   first_one(rec_to_t), 17);
    check_eq("t3_to_cnt",     $countones(rec_to_t), 1);
    check_eq("t3_pipe_first", first_one(rec_pipe_t), 17);
    check_eq("t3_pipe_cnt",   $countones(rec_pipe_t), 4);
    check_eq("t3_done_cyc",   first_one(rec_done_t), 29);
    check_eq("t3_done_cnt",   $countones(rec_done_t), 1);
    check_eq("t3_dflt_no_to", $countones(rec_to), 0);

    // A second req in cycle 3 (during PULSE) is ignored.
    do_reset();
    run_seq(32, 0, 0, 3, -1);
    check_eq("t4_pipe_cnt",   $countones(rec_pipe), 4);
    check_eq("t4_pipe_last",  last_one(rec_pipe), 5);
    check_eq("t4_done_cnt",   $countones(rec_done), 1);
    check_eq("t4_done_cyc",   first_one(rec_done), 14);

    // Reset in cycle 8 (SETTLE): the sequence aborts and never completes.
    do_reset();
    run_seq(32, 0, 0, -1, 8);
    check_eq("t5_done_cnt",   $countones(rec_done), 0);
    check_eq("t5_busy_last",  last_one(rec_busy), 7);
    check_eq("t5_pipe_cnt",   $countones(rec_pipe), 4);
    check_eq("t5_end_state",  int'(st_d), int'(FT_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_rst_fencet_ctrl.md
CT_RST_FENCET_CTRL -- requirements
Module: ct_rst_fencet_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4: number of cycles pipe4_fencet is held high.
REQ-002 SHALL have parameter SETTLE_CYC, default 8: cycles waited after pulse before completion; legal range >=3.
REQ-003 SHALL have parameter DRAIN_MAX, default 1023: drain-wait cycles before forced progress; counter width is clog2(DRAIN_MAX+1).
REQ-004 SHALL have port forever_coreclk, input, 1: the single clock, free-running and ungated.
REQ-005 SHALL have port cpurst_b, input, 1: asynchronous active-low reset from the architectural reset domain, which is not cleared by fence.t.
REQ-006 SHALL have port rtu_fencet_req, input, 1: single-cycle pulse when a fence.t retires.
REQ-007 SHALL have ports lsu_fencet_idle, ifu_fencet_idle and biu_fencet_idle, input, 1 each: unit quiescent, with no outstanding transactions.
REQ-008 SHALL have port pipe4_fencet, output, 1: registered microarchitectural reset request to the reset top.
REQ-009 SHALL have port fencet_busy, output, 1: sequence in progress; the front end stalls issue while it is high.
REQ-010 SHALL have port fencet_done, output, 1: single-cycle completion pulse to the RTU.
REQ-011 SHALL have port fencet_timeout, output, 1: single-cycle pulse when the drain wait hits DRAIN_MAX.

Function
REQ-012 SHALL implement the FSM states IDLE, DRAIN, PULSE, SETTLE and DONE, one-hot or binary.
REQ-013 IDLE SHALL go to DRAIN on rtu_fencet_req and clear the drain counter; rtu_fencet_req SHALL be ignored in all other states.
REQ-014 DRAIN SHALL go to PULSE in the first cycle all three idle inputs are high in the same cycle, loading the counter with PULSE_CYC-1.
REQ-015 In DRAIN, the counter SHALL increment each cycle; at DRAIN_MAX the block SHALL pulse fencet_timeout for one cycle and go to PULSE regardless of the idle inputs.
REQ-016 In PULSE, pipe4_fencet SHALL be high; the counter SHALL decrement; at 0 the FSM SHALL go to SETTLE, loading SETTLE_CYC-1.
REQ-017 In SETTLE, pipe4_fencet SHALL be low; at counter 0 the FSM SHALL go to DONE.
REQ-018 In DONE, fencet_done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 pipe4_fencet SHALL be a flop output decoded from next-state; it SHALL be glitch-free and high for exactly PULSE_CYC consecutive cycles per sequence.
REQ-020 fencet_busy SHALL be high in DRAIN, PULSE, SETTLE and DONE, and low only in IDLE.
REQ-021 Latency with idle inputs already high SHALL be: req at cycle 0; pipe4_fencet high from cycle 2 to cycle 1+PULSE_CYC; fencet_done at cycle 2+PULSE_CYC+SETTLE_CYC.
REQ-022 Idle inputs SHALL be ignored outside DRAIN; an idle deassertion during PULSE or SETTLE SHALL have no effect.
REQ-023 In DRAIN, if all idle inputs are high in the same cycle the counter reaches DRAIN_MAX, the FSM SHALL go to PULSE and fencet_timeout SHALL NOT pulse.
REQ-024 SETTLE_CYC >= 3 SHALL cover the reset top's one-cycle fence latch plus its per-unit reset flop, so every unit reset is released before fencet_done.

Reset
REQ-025 On cpurst_b low, the block SHALL asynchronously enter IDLE, clear the counter, and drive pipe4_fencet, fencet_busy, fencet_done and fencet_timeout to 0.
REQ-026 A cpurst_b assertion mid-sequence SHALL abort the sequence with no completion pulse, and the sequence SHALL NOT resume after reset release.
REQ-027 The block SHALL be clocked by forever_coreclk and reset only by cpurst_b; pipe4_fencet SHALL NOT reset this block.

Structure
REQ-028 State encodings and the default values of PULSE_CYC, SETTLE_CYC and DRAIN_MAX SHALL be localparams in the shared reset package (ct_rst_pkg).
REQ-029 The block SHALL be a single module with one shared down/up counter, no sub-modules, and be instantiated next to ct_rst_top.

Verification
REQ-030 A bench SHALL check: req with all idle inputs high, defaults -> pipe4_fencet high cycles 2-5, fencet_done at cycle 14, busy cycles 1-14.
REQ-031 A bench SHALL check: req with lsu idle low for 20 cycles -> pipe4_fencet rises 1 cycle after lsu idle rises, with no timeout.
REQ-032 A bench SHALL check: req with biu idle stuck low, DRAIN_MAX=15 -> fencet_timeout pulses once after 15 drain cycles, then a normal pulse and fencet_done.
REQ-033 A bench SHALL check: second req during PULSE -> ignored, with exactly one fencet_done and one 4-cycle pulse.
REQ-034 A bench SHALL check: cpurst_b low during SETTLE -> all outputs 0 immediately, and no fencet_done after release.
REQ-035 A bench SHALL check, together with the reset top: ifu_rst_b low for PULSE_CYC cycles and released before fencet_done.
